// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl_pkg
//  Purpose  : Shared display constants for the multiplexed 8-digit
//             seven-segment scanner: digit count, nibble width and the
//             active-low segment patterns (bit 7 = dp, bits 6..0 = g..a).
//  Revision : 1.0 - initial release
// ============================================================================
package seg_scan_ctrl_pkg;

  localparam int c_num_digits = 8;
  localparam int c_nibble_w   = 4;
  localparam int c_idx_w      = 3;

  typedef logic [c_nibble_w-1:0] nibble_t;
  typedef logic [7:0]            segs_t;

  // All segments and the decimal point off
  localparam segs_t c_seg_blank = 8'hFF;

  // Active-low glyphs; the dp bit is left off (1) and replaced downstream
  localparam segs_t c_seg_hex_0 = 8'hC0;
  localparam segs_t c_seg_hex_1 = 8'hF9;
  localparam segs_t c_seg_hex_2 = 8'hA4;
  localparam segs_t c_seg_hex_3 = 8'hB0;
  localparam segs_t c_seg_hex_4 = 8'h99;
  localparam segs_t c_seg_hex_5 = 8'h92;
  localparam segs_t c_seg_hex_6 = 8'h82;
  localparam segs_t c_seg_hex_7 = 8'hF8;
  localparam segs_t c_seg_hex_8 = 8'h80;
  localparam segs_t c_seg_hex_9 = 8'h98;
  localparam segs_t c_seg_hex_a = 8'h88;
  localparam segs_t c_seg_hex_b = 8'h83;
  localparam segs_t c_seg_hex_c = 8'hC6;
  localparam segs_t c_seg_hex_d = 8'hA1;
  localparam segs_t c_seg_hex_e = 8'h86;
  localparam segs_t c_seg_hex_f = 8'h8E;

  // One-hot active-low anode pattern for a digit index
  function automatic logic [c_num_digits-1:0] anode_for(input logic [c_idx_w-1:0] idx);
    logic [c_num_digits-1:0] onehot;
    onehot    = '0;
    onehot[idx] = 1'b1;
    return ~onehot;
  endfunction

endpackage : seg_scan_ctrl_pkg
`default_nettype wire

// File: rtl/seg_scan_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : hex_seg_decode
//  Purpose  : Combinational hex nibble to active-low seven-segment decode.
//             Bit 7 (dp) is always returned off; the caller overrides it.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_seg_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  // Table lookup of the glyph for the incoming nibble
  always_comb begin
    seg = c_seg_blank;
    case (nibble)
      4'h0:    seg = c_seg_hex_0;
      4'h1:    seg = c_seg_hex_1;
      4'h2:    seg = c_seg_hex_2;
      4'h3:    seg = c_seg_hex_3;
      4'h4:    seg = c_seg_hex_4;
      4'h5:    seg = c_seg_hex_5;
      4'h6:    seg = c_seg_hex_6;
      4'h7:    seg = c_seg_hex_7;
      4'h8:    seg = c_seg_hex_8;
      4'h9:    seg = c_seg_hex_9;
      4'hA:    seg = c_seg_hex_a;
      4'hB:    seg = c_seg_hex_b;
      4'hC:    seg = c_seg_hex_c;
      4'hD:    seg = c_seg_hex_d;
      4'hE:    seg = c_seg_hex_e;
      4'hF:    seg = c_seg_hex_f;
      default: seg = c_seg_blank;
    endcase
  end

endmodule : hex_seg_decode
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed 8-digit seven-segment scanner. Each digit owns
//             a CLK_DIV-cycle slot whose first BLANK cycles keep the anodes
//             off to suppress ghosting. New data is staged in a shadow
//             register and only promoted to the display at a frame boundary,
//             so a frame never mixes old and new digits.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int BLANK   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dot_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        ack
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]      c_cnt_last  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]      c_blank_end = CW'(BLANK);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(c_num_digits - 1);

  logic [CW-1:0]      r_cnt;
  logic [c_idx_w-1:0] r_idx;
  logic [31:0]        r_shadow;
  logic [31:0]        r_display;
  logic               r_pending;
  logic               r_ack;
  logic [7:0]         r_an;
  logic [7:0]         r_seg;

  logic               w_slot_end;
  logic               w_frame_wrap;
  logic               w_commit;
  logic               w_lit;
  logic [3:0]         w_nibble;
  logic [7:0]         w_glyph;

  assign w_slot_end   = (r_cnt == c_cnt_last);
  assign w_frame_wrap = w_slot_end && (r_idx == c_idx_last);
  assign w_commit     = w_frame_wrap && r_pending;

  // A digit is driven only once its blanking window is over and it is enabled
  assign w_lit    = (r_cnt >= c_blank_end) && digit_en[r_idx];
  assign w_nibble = r_display[{r_idx, 2'b00} +: c_nibble_w];

  hex_seg_decode u_decode (
    .nibble (w_nibble),
    .seg    (w_glyph)
  );

  // Slot timer and digit index; the index advances on the last cycle of a slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Shadow capture and frame-aligned promotion; a load on the commit edge
  // re-arms pending so the fresh value goes out at the next frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_display <= '0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_commit;
      if (w_commit) begin
        r_display <= r_shadow;
        r_pending <= 1'b0;
      end
      if (load) begin
        r_shadow  <= data_in;
        r_pending <= 1'b1;
      end
    end
  end

  // Registered pin drivers, blank unless the current digit is lit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= c_seg_blank;
      r_seg <= c_seg_blank;
    end else if (w_lit) begin
      r_an  <= anode_for(r_idx);
      r_seg <= {~dot_en[r_idx], w_glyph[6:0]};
    end else begin
      r_an  <= c_seg_blank;
      r_seg <= c_seg_blank;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign ack = r_ack;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000: clocks per digit slot; legal range is 2 or more.
REQ-002 SHALL have parameter BLANK, default 1000: anode-off cycles at the start of each slot; legal range is 0 to CLK_DIV-1.
REQ-003 SHALL use one clock; reset is synchronous and active-low; the ports are named clk and rst_n.
REQ-004 SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, width 1: synchronous active-low reset.
REQ-006 SHALL have port data_in, input, width 32: eight hex nibbles, where digit i is data_in[4i+3:4i].
REQ-007 SHALL have port load, input, width 1: one-cycle strobe that captures data_in.
REQ-008 SHALL have port digit_en, input, width 8: bit i=1 enables digit i; sampled live.
REQ-009 SHALL have port dot_en, input, width 8: bit i=1 lights the decimal point of digit i; sampled live.
REQ-010 SHALL have port an, output, width 8: active-low digit anodes.
REQ-011 SHALL have port seg, output, width 8: active-low segments, bit 7 = dp, bits 6..0 = g..a.
REQ-012 SHALL have port ack, output, width 1: one-cycle pulse when loaded data becomes visible.

Function
REQ-013 SHALL keep the slot counter cnt counting 0..CLK_DIV-1 and wrapping to 0.
REQ-014 SHALL increment digit index idx (3 bits) when cnt==CLK_DIV-1, wrapping 7 to 0; a frame is 8*CLK_DIV cycles.
REQ-015 SHALL write data_in into the shadow register on load=1 and set pending=1.
REQ-016 SHALL, on a frame wrap (idx==7 and cnt==CLK_DIV-1) with pending=1, copy shadow to the display register, clear pending, and drive ack=1 for exactly the next cycle.
REQ-017 SHALL, when load coincides with a frame-wrap commit, commit the pre-edge shadow, write the new data_in into shadow, and leave pending=1 so the new data commits at the following wrap.
REQ-018 SHALL treat multiple loads before a commit as overwrites: only the last value is shown, with a single ack.
REQ-019 SHALL never change the display register mid-frame (no tearing).
REQ-020 SHALL register an and seg with one-cycle latency from (cnt, idx).
REQ-021 SHALL drive an[idx]=0 and all other an bits 1 when cnt>=BLANK and digit_en[idx]=1; otherwise an=8'hFF.
REQ-022 SHALL drive seg[6:0] from the hex decode of display nibble idx, and seg[7]=~dot_en[idx], whenever an is active.
REQ-023 SHALL drive seg=8'hFF whenever an=8'hFF (during blanking or with the digit disabled).
REQ-024 SHALL use the decode table 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98, A=88, B=83, C=C6, D=A1, E=86, F=8E (hex, bit 7 masked by dp).

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear cnt, idx, shadow, display, pending and ack.
REQ-026 SHALL hold an=8'hFF and seg=8'hFF from reset until scanning resumes.
REQ-027 SHALL, on reset mid-frame, discard pending data with no ack, and restart scanning from digit 0, cnt 0, on the first cycle with rst_n=1.
REQ-028 SHALL ignore load in any cycle where rst_n=0.

Structure
REQ-029 SHALL place the active-low segment constants, plus the blank value 8'hFF, in a shared display package alongside the digit count (8) and nibble width (4).
REQ-030 SHALL instantiate one combinational sub-module, hex_seg_decode (4-bit in, 8-bit out, table per REQ-024), feeding the output register.
REQ-031 SHALL be fully synchronous with no derived clocks; the counter width is $clog2(CLK_DIV).

Verification (CLK_DIV=4, BLANK=1)
REQ-032 SHALL cover: reset, then run 32 cycles -> an walks FE, FD, ... 7F, each low for 3 cycles after 1 blank cycle at FF; seg=C0 on active digits.
REQ-033 SHALL cover: load data_in=32'h89ABCDEF mid-frame -> no display change until the wrap; ack pulses once; digit 0 shows 8E, digit 7 shows 80.
REQ-034 SHALL cover: load 32'h11111111, then 32'h22222222 before the wrap -> a single ack; all digits show A4.
REQ-035 SHALL cover: load asserted exactly at a frame-wrap cycle with pending set -> the old shadow commits with ack, pending stays 1, and the new value commits with a second ack one frame later.
REQ-036 SHALL cover: digit_en=8'h0F, dot_en=8'h01 -> digits 4-7 give an=FF and seg=FF; digit 0 shows seg bit 7=0.
REQ-037 SHALL cover: rst_n low for 1 cycle mid-slot with pending=1 -> outputs FF, no ack, display=0, scanning restarts at digit 0.
